load_wb_arbiter: RTL

LOAD_WB_ARBITER -- requirements
Module: load_wb_arbiter

---
 rtl/load_wb_arbiter_if.sv | 37 +++
 rtl/load_wb_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/load_wb_arbiter_if.sv
// Bundle of load-result, ALU-result and register-file writeback signals
// shared between the writeback arbiter and its neighbours.
interface load_wb_arbiter_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     mem_enable;
   logic                     mem_float;
   logic [4:0]               mem_addr;
   logic [31:0]              mem_data;
   logic                     alu_enable;
   logic                     alu_float;
   logic [4:0]               alu_addr;
   logic [31:0]              alu_data;
   logic                     wb_enable;
   logic                     wb_float;
   logic [4:0]               wb_addr;
   logic [31:0]              wb_data;
   logic                     stall;
   logic [$clog2(DEPTH):0]   pending;
   logic                     overflow;

   // Request side: SRAM manager / ALU / dispatch / register file.
   modport master (
      output mem_enable, mem_float, mem_addr, mem_data,
      output alu_enable, alu_float, alu_addr, alu_data,
      input  wb_enable, wb_float, wb_addr, wb_data,
      input  stall, pending, overflow
   );

   // Arbiter side.
   modport slave (
      input  mem_enable, mem_float, mem_addr, mem_data,
      input  alu_enable, alu_float, alu_addr, alu_data,
      output wb_enable, wb_float, wb_addr, wb_data,
      output stall, pending, overflow
   );
endinterface

// File: rtl/load_wb_arbiter.sv
// Single-port register-file writeback arbiter. Load results always win;
// ALU results that lose arbitration are queued in a small FIFO and drained
// in arrival order ahead of any new direct ALU write.
module load_wb_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   load_wb_arbiter_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 38;   // {float, addr[4:0], data[31:0]}

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   logic [EW-1:0] fifo_mem [DEPTH];
   logic [EW-1:0] head;
   logic          empty, full;
   logic          pop, push, push_ok, drop;
   logic          sel_enable;
   logic [EW-1:0] sel_word;
   logic          stall_next;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = fifo_mem[rd_ptr[AW-1:0]];
   assign bus.pending = count;

   // FIFO control and writeback source selection for the coming edge.
   always_comb begin
      pop        = 1'b0;
      push       = 1'b0;
      sel_enable = 1'b0;
      sel_word   = '0;
      if (bus.mem_enable) begin
         sel_enable = 1'b1;
         sel_word   = {bus.mem_float, bus.mem_addr, bus.mem_data};
         push       = bus.alu_enable;
      end else if (!empty) begin
         sel_enable = 1'b1;
         sel_word   = head;
         pop        = 1'b1;
         push       = bus.alu_enable;
      end else if (bus.alu_enable) begin
         sel_enable = 1'b1;
         sel_word   = {bus.alu_float, bus.alu_addr, bus.alu_data};
      end
      // A pop in the same cycle frees the slot, so full+pop still accepts.
      push_ok    = push && (!full || pop);
      drop       = push && !push_ok;
      count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      stall_next = (count_next >= (AW+1)'(DEPTH - 1));
   end

   // Pointer, status and registered writeback outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.wb_enable <= 1'b0;
         bus.wb_float  <= 1'b0;
         bus.wb_addr   <= '0;
         bus.wb_data   <= '0;
         bus.stall     <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         bus.wb_enable <= sel_enable;
         if (sel_enable) begin
            bus.wb_float <= sel_word[37];
            bus.wb_addr  <= sel_word[36:32];
            bus.wb_data  <= sel_word[31:0];
         end
         bus.stall <= stall_next;
         if (drop) bus.overflow <= 1'b1;
      end
   end

   // Queue storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr[AW-1:0]] <= {bus.alu_float, bus.alu_addr, bus.alu_data};
   end
endmodule
